// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential add/sub unit: field widths,
// FSM state encoding, field extraction and the zero-operand predicate.
package fp32_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int EXP_WIDTH          = 8;
  localparam int SIGNIFICANDS_WIDTH = 23;
  localparam int ADDER_WIDTH        = 25;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_e;

  function automatic logic fp_sign(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1];
  endfunction

  function automatic logic [EXP_WIDTH-1:0] fp_exp(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-2 -: EXP_WIDTH];
  endfunction

  function automatic logic [SIGNIFICANDS_WIDTH-1:0] fp_frac(input logic [DATA_WIDTH-1:0] x);
    return x[SIGNIFICANDS_WIDTH-1:0];
  endfunction

  // Exponent field 0 means zero: denormals are flushed.
  function automatic logic fp_is_zero(input logic [DATA_WIDTH-1:0] x);
    return fp_exp(x) == '0;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Alignment shifter: moves the smaller significand right by the exponent
// difference. Bits shifted out are truncated; a difference of WIDTH or more
// yields zero.
module fp_align_shift #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 8
) (
  input  logic [WIDTH-1:0]   sig_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [WIDTH-1:0]   sig_o
);

  assign sig_o = (shift_i >= SHIFT_W'(WIDTH)) ? '0 : (sig_i >> shift_i);

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential FP32 adder/subtractor. An FSM steps through alignment, one
// shared significand add/subtract and a one-bit-per-cycle normalizer,
// trading latency for area. Truncating, no NaN/Inf input handling.
// Optional build macro FP_STATUS_EN adds status = {overflow, underflow, zero}.
module fp_addsub_seq #(
  parameter int DATA_WIDTH         = fp32_pkg::DATA_WIDTH,
  parameter int EXP_WIDTH          = fp32_pkg::EXP_WIDTH,
  parameter int SIGNIFICANDS_WIDTH = fp32_pkg::SIGNIFICANDS_WIDTH,
  parameter int ADDER_WIDTH        = fp32_pkg::ADDER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
`ifdef FP_STATUS_EN
  ,
  output logic [2:0]            status
`endif
);

  import fp32_pkg::*;

  localparam int MW = SIGNIFICANDS_WIDTH + 1;  // hidden bit + fraction

  state_e                        state_q;
  logic [DATA_WIDTH-1:0]         op_a_q, op_b_q;
  logic                          sign_q, eff_sub_q;
  logic [EXP_WIDTH-1:0]          exp_q;
  logic [MW-1:0]                 ml_q, ms_q;
  logic [ADDER_WIDTH-1:0]        sum_q;
  logic [4:0]                    cnt_q;
  logic [DATA_WIDTH-1:0]         result_q;
  logic                          out_valid_q, in_ready_q, busy_q;
`ifdef FP_STATUS_EN
  logic [2:0]                    status_q;
`endif

  // Effective B: subtraction is folded into B's sign at capture.
  logic [DATA_WIDTH-1:0] b_eff;
  assign b_eff = {fp_sign(op_b) ^ op_sub, op_b[DATA_WIDTH-2:0]};

  // Operand ordering: larger magnitude becomes L; an exact tie keeps A as L.
  logic                  swap;
  logic [DATA_WIDTH-1:0] l_op, s_op;
  logic [EXP_WIDTH-1:0]  diff;
  logic [MW-1:0]         ms_d;
  assign swap = op_b_q[DATA_WIDTH-2:0] > op_a_q[DATA_WIDTH-2:0];
  assign l_op = swap ? op_b_q : op_a_q;
  assign s_op = swap ? op_a_q : op_b_q;
  assign diff = fp_exp(l_op) - fp_exp(s_op);

  fp_align_shift #(
    .WIDTH   (MW),
    .SHIFT_W (EXP_WIDTH)
  ) u_align (
    .sig_i   ({1'b1, fp_frac(s_op)}),
    .shift_i (diff),
    .sig_o   (ms_d)
  );

  // The single significand adder; L >= S so subtraction never goes negative.
  logic [ADDER_WIDTH-1:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                           : ({1'b0, ml_q} + {1'b0, ms_q});

  // Normalizer helpers for the current NORM cycle.
  logic [SIGNIFICANDS_WIDTH-1:0] frac_shl;
  logic [EXP_WIDTH-1:0]          exp_inc, exp_dec;
  assign frac_shl = {sum_q[SIGNIFICANDS_WIDTH-2:0], 1'b0};
  assign exp_inc  = exp_q + 1'b1;
  assign exp_dec  = exp_q - 1'b1;

  // Control FSM plus datapath registers; all outputs are registered here.
  // NOTE: every register in this block uses <= so each branch sees the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control state and visible outputs are reset; datapath
      // registers are always written before they are read.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
`ifdef FP_STATUS_EN
      status_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_a_q     <= op_a;
            op_b_q     <= b_eff;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (fp_is_zero(op_a) || fp_is_zero(op_b)) begin
              result_q    <= fp_is_zero(op_a) ? b_eff : op_a;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
`ifdef FP_STATUS_EN
              status_q    <= {2'b00, fp_is_zero(op_a) && fp_is_zero(op_b)};
`endif
            end else begin
              state_q <= S_ALIGN;
            end
          end
        end

        S_ALIGN: begin
          sign_q    <= fp_sign(l_op);
          eff_sub_q <= fp_sign(l_op) ^ fp_sign(s_op);
          exp_q     <= fp_exp(l_op);
          ml_q      <= {1'b1, fp_frac(l_op)};
          ms_q      <= ms_d;
          state_q   <= S_ADD;
        end

        S_ADD: begin
          if (sum_d == '0) begin
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
`ifdef FP_STATUS_EN
            status_q    <= 3'b001;
`endif
          end else begin
            sum_q   <= sum_d;
            cnt_q   <= '0;
            state_q <= S_NORM;
          end
        end

        S_NORM: begin
          if (sum_q[ADDER_WIDTH-1]) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
            if (exp_q >= EXP_MAX - 1'b1) begin
              result_q <= {sign_q, EXP_MAX, {SIGNIFICANDS_WIDTH{1'b0}}};
`ifdef FP_STATUS_EN
              status_q <= 3'b100;
`endif
            end else begin
              result_q <= {sign_q, exp_inc, sum_q[SIGNIFICANDS_WIDTH:1]};
            end
          end else if (sum_q[SIGNIFICANDS_WIDTH]) begin
            result_q    <= {sign_q, exp_q, sum_q[SIGNIFICANDS_WIDTH-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (exp_q <= 1) begin
            // One more left shift would take the exponent to 0: flush.
            result_q    <= {sign_q, {(DATA_WIDTH-1){1'b0}}};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
`ifdef FP_STATUS_EN
            status_q    <= 3'b011;
`endif
          end else begin
            sum_q <= {sum_q[ADDER_WIDTH-2:0], 1'b0};
            exp_q <= exp_dec;
            cnt_q <= cnt_q + 1'b1;
            // Finish on the shift that brings the leading one to the hidden
            // position, so k shifts cost exactly k NORM cycles.
            if (sum_q[SIGNIFICANDS_WIDTH-1] || cnt_q == 5'd22) begin
              result_q    <= {sign_q, exp_dec, frac_shl};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
`ifdef FP_STATUS_EN
            status_q    <= '0;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
`ifdef FP_STATUS_EN
  assign status    = status_q;
`endif

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed FP32 vectors, latency
// measured from the accept edge, hold/backpressure and mid-operation reset.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;
`ifdef FP_STATUS_EN
  logic [2:0]  status;
`endif

  int checks = 0;
  int errors = 0;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef FP_STATUS_EN
    ,
    .status    (status)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one operation, then count edges (accept edge = 1) until out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ovalid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_iready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // 1.0 + 1.0: carry out, right-normalize
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, "one_plus_one");
    handshake("one_plus_one");

    // 1.5 - 1.25 = 0.25: two left shifts
    run_op(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 5, "sub_k2");
    handshake("sub_k2");

    // Zero bypass both ways
    run_op(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1, "zero_a");
    handshake("zero_a");
    run_op(32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 1, "zero_b");
    handshake("zero_b");

    // Exact cancellation
    run_op(32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3, "cancel");
`ifdef FP_STATUS_EN
    check("cancel_status", {29'b0, status}, 32'd1);
`endif
    handshake("cancel");

    // Swap with sign: 1.0 - 2.0 = -1.0
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4, "swap_neg");
    handshake("swap_neg");

    // Alignment boundaries: diff 23 keeps one bit, diff 24 drops everything
    run_op(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4, "align_d23");
    handshake("align_d23");
    run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4, "align_d24");
    handshake("align_d24");

    // Exponent underflow during normalization flushes to zero
    run_op(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4, "underflow");
    handshake("underflow");

    // Overflow to infinity with backpressure held for 3 cycles
    out_ready = 1'b0;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4, "overflow");
`ifdef FP_STATUS_EN
    check("overflow_status", {29'b0, status}, 32'd4);
`endif
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, 32'h7F800000);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    handshake("overflow");
    check("post_hold_busy", {31'b0, busy}, 32'd0);

    // Reset during the 3rd NORM cycle of a k=23 operation
    op_a = 32'h3F800001; op_b = 32'h3F800000; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_norm_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", result, 32'h0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 32'd0);

    // Same operation run to completion: 23 left shifts
    run_op(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 26, "k23");
    handshake("k23");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
